// File: rtl/reg_access_arbiter_pkg.sv
// Shared encodings for the register-port arbiter: FSM states, port enable codes, address map limits.
// Helpers classify addresses so the top decides write legality and read errors from one place.
package reg_access_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   localparam logic [1:0] RIO_IDLE = 2'b00;
   localparam logic [1:0] RIO_WR   = 2'b10;
   localparam logic [1:0] RIO_RD   = 2'b11;

   localparam logic [6:0] RIO_BUNDLE_HI = 7'd43;
   localparam logic [6:0] RIO_USER_LO   = 7'd50;
   localparam logic [6:0] RIO_USER_HI   = 7'd57;

   // Only the user register window accepts writes.
   function automatic logic wr_legal(input logic [6:0] addr);
      return (addr >= RIO_USER_LO) && (addr <= RIO_USER_HI);
   endfunction

   // The hole between the bundle registers and the user window, and everything above it, is unmapped.
   function automatic logic rd_error(input logic [6:0] addr);
      return ((addr > RIO_BUNDLE_HI) && (addr < RIO_USER_LO)) || (addr > RIO_USER_HI);
   endfunction

endpackage

// File: rtl/reg_access_arbiter_if.sv
// Requester-side bundle of the register arbiter: level requests with flattened address/data, one-hot ack.
// master = requesters, slave = arbiter; requests are held until the matching ack pulse.
interface reg_access_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]    req;
   logic [NUM_REQ-1:0]    req_we;
   logic [7*NUM_REQ-1:0]  req_addr;
   logic [32*NUM_REQ-1:0] req_wdata;
   logic [NUM_REQ-1:0]    ack;
   logic [31:0]           rsp_rdata;
   logic                  rsp_err;

   modport master (
      output req, req_we, req_addr, req_wdata,
      input  ack, rsp_rdata, rsp_err
   );

   modport slave (
      input  req, req_we, req_addr, req_wdata,
      output ack, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping; zero latency.
// No state; any=0 when nothing is requested and grant is then 0.
module rr_priority_select #(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   grant,
   output logic               any
);

   always_comb begin
      int idx;
      grant = '0;
      any   = 1'b0;
      idx   = 0;
      // Walk from the farthest position back to ptr so the closest requester is written last.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = (int'(ptr) + i) % NUM_REQ;
         if (req[idx]) begin
            grant = IDX_W'(idx);
            any   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reg_access_arbiter.sv
// Round-robin owner of the single register port: 3 cycles per legal access (IDLE/ACCESS/RESP), 2 for a rejected write.
// Requesters hold req until their one-cycle ack; losers simply stay pending.
module reg_access_arbiter
   import reg_access_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   reg_access_arbiter_if.slave  req_if,
   output logic                 busy,
   output logic [1:0]           rio_enable,
   output logic [6:0]           rio_addr,
   output logic [31:0]          rio_datain,
   input  logic [31:0]          rio_dataout
);

   localparam int IDX_W = $clog2(NUM_REQ);

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d;
   logic [IDX_W-1:0]     gnt_q, gnt_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic [31:0]          rsp_rdata_q, rsp_rdata_d;
   logic                 rsp_err_q, rsp_err_d;
   logic [1:0]           rio_enable_q, rio_enable_d;
   logic [6:0]           rio_addr_q, rio_addr_d;
   logic [31:0]          rio_datain_q, rio_datain_d;

   logic [IDX_W-1:0]     sel_idx;
   logic                 sel_any;
   logic                 sel_we;
   logic [6:0]           sel_addr;
   logic [31:0]          sel_wdata;

   rr_priority_select #(.NUM_REQ(NUM_REQ)) u_rr_priority_select (
      .req   (req_if.req),
      .ptr   (ptr_q),
      .grant (sel_idx),
      .any   (sel_any)
   );

   assign sel_we    = req_if.req_we[sel_idx];
   assign sel_addr  = req_if.req_addr[int'(sel_idx)*7 +: 7];
   assign sel_wdata = req_if.req_wdata[int'(sel_idx)*32 +: 32];

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      gnt_d        = gnt_q;
      ack_d        = ack_q;
      rsp_rdata_d  = rsp_rdata_q;
      rsp_err_d    = rsp_err_q;
      rio_enable_d = rio_enable_q;
      rio_addr_d   = rio_addr_q;
      rio_datain_d = rio_datain_q;
      case (state_q)
         IDLE: begin
            if (sel_any) begin
               gnt_d = sel_idx;
               ptr_d = (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
               if (sel_we && !wr_legal(sel_addr)) begin
                  // Rejected writes never touch the port; answer straight away with an error.
                  rsp_err_d      = 1'b1;
                  ack_d          = '0;
                  ack_d[sel_idx] = 1'b1;
                  state_d        = RESP;
               end else begin
                  rio_addr_d   = sel_addr;
                  rio_datain_d = sel_we ? sel_wdata : 32'h0;
                  rio_enable_d = sel_we ? RIO_WR : RIO_RD;
                  state_d      = ACCESS;
               end
            end
         end
         ACCESS: begin
            if (rio_enable_q == RIO_RD) begin
               rsp_rdata_d = rio_dataout;
               rsp_err_d   = rd_error(rio_addr_q);
            end
            rio_enable_d = RIO_IDLE;
            ack_d        = '0;
            ack_d[gnt_q] = 1'b1;
            state_d      = RESP;
         end
         RESP: begin
            ack_d       = '0;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = 32'h0;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         gnt_q        <= '0;
         ack_q        <= '0;
         rsp_rdata_q  <= 32'h0;
         rsp_err_q    <= 1'b0;
         rio_enable_q <= RIO_IDLE;
         rio_addr_q   <= 7'h0;
         rio_datain_q <= 32'h0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         gnt_q        <= gnt_d;
         ack_q        <= ack_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_err_q    <= rsp_err_d;
         rio_enable_q <= rio_enable_d;
         rio_addr_q   <= rio_addr_d;
         rio_datain_q <= rio_datain_d;
      end
   end

   assign busy             = (state_q != IDLE);
   assign rio_enable       = rio_enable_q;
   assign rio_addr         = rio_addr_q;
   assign rio_datain       = rio_datain_q;
   assign req_if.ack       = ack_q;
   assign req_if.rsp_rdata = rsp_rdata_q;
   assign req_if.rsp_err   = rsp_err_q;

endmodule
